// File: rtl/rot_matrix_gen.sv
// rot_matrix_gen: three Q4.8 Euler angles -> R = Rz*Ry*Rx, nine Q2.12 entries, one result per 7 cycles.
// Build option ROTM_SAT_EN: clamp every product and sum to [-1.0, +1.0]; otherwise results wrap at 14 bits.

// Sine of a Q16 phase in [0, 2*pi): fold into [0, pi/2] and evaluate a 7th-order odd polynomial.
module rot_trig_q16 #(
  parameter int WE  = 14,
  parameter int WOF = 12
) (
  input  logic [18:0]          i_phase,
  output logic signed [WE-1:0] o_sin
);
  localparam logic [18:0] PI_Q16  = 19'd205887;
  localparam logic [18:0] HPI_Q16 = 19'd102944;

  logic          w_neg;
  logic [18:0]   w_p1;
  logic [16:0]   w_x;
  logic [17:0]   w_x2;
  logic [16:0]   w_t3;
  logic [16:0]   w_t2;
  logic [16:0]   w_t1;
  logic [16:0]   w_s;
  logic [WE-1:0] w_mag;

  always_comb begin
    w_neg = (i_phase >= PI_Q16);
    w_p1  = w_neg ? (i_phase - PI_Q16) : i_phase;
    w_x   = (w_p1 > HPI_Q16) ? 17'(PI_Q16 - w_p1) : 17'(w_p1);
    w_x2  = 18'((40'(w_x) * 40'(w_x)) >> 16);
    // Horner form of x - x^3/6 + x^5/120 - x^7/5040 with Q16 coefficients 1/42, 1/20, 1/6
    w_t3  = 17'(40'd65536 - ((40'(w_x2) * 40'd1560) >> 16));
    w_t2  = 17'(40'd65536 - ((((40'(w_x2) * 40'(w_t3)) >> 16) * 40'd3277) >> 16));
    w_t1  = 17'(40'd65536 - ((((40'(w_x2) * 40'(w_t2)) >> 16) * 40'd10923) >> 16));
    w_s   = 17'((40'(w_x) * 40'(w_t1)) >> 16);
    w_mag = WE'((40'(w_s) + 40'(1 << (15 - WOF))) >> (16 - WOF));
    o_sin = w_neg ? -$signed(w_mag) : $signed(w_mag);
  end
endmodule

module cal_sin #(
  parameter int WA  = 12,
  parameter int WIF = 8,
  parameter int WE  = 14,
  parameter int WOF = 12
) (
  input  logic [WA-1:0]        i_angle,
  output logic signed [WE-1:0] o_sin
);
  logic [18:0] w_phase;

  assign w_phase = 19'(i_angle) << (16 - WIF);

  rot_trig_q16 #(.WE(WE), .WOF(WOF)) u_core (
    .i_phase (w_phase),
    .o_sin   (o_sin)
  );
endmodule

// cos(a) = sin(a + pi/2), re-wrapped into [0, 2*pi) before the shared evaluator.
module cal_cos #(
  parameter int WA  = 12,
  parameter int WIF = 8,
  parameter int WE  = 14,
  parameter int WOF = 12
) (
  input  logic [WA-1:0]        i_angle,
  output logic signed [WE-1:0] o_cos
);
  logic [19:0] w_sum;
  logic [18:0] w_phase;

  assign w_sum   = (20'(i_angle) << (16 - WIF)) + 20'd102944;
  assign w_phase = (w_sum >= 20'd411775) ? 19'(w_sum - 20'd411775) : 19'(w_sum);

  rot_trig_q16 #(.WE(WE), .WOF(WOF)) u_core (
    .i_phase (w_phase),
    .o_sin   (o_cos)
  );
endmodule

module rot_matrix_gen #(
  parameter int WII = 4,
  parameter int WIF = 8,
  parameter int WOI = 2,
  parameter int WOF = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WII+WIF-1:0]         angle_x,
  input  logic [WII+WIF-1:0]         angle_y,
  input  logic [WII+WIF-1:0]         angle_z,
  output logic                       busy,
  output logic                       done,
  output logic [9*(WOI+WOF)-1:0]     m_out
);
  localparam int WA = WII + WIF;
  localparam int WE = WOI + WOF;

  localparam logic [WA-1:0] TWO_PI = WA'(32'h648);
  localparam logic [WE-1:0] E_ONE  = WE'(1 << WOF);
  localparam logic [WE-1:0] E_ZERO = '0;
  localparam logic [9*WE-1:0] IDENT = {E_ONE, {3{E_ZERO}}, E_ONE, {3{E_ZERO}}, E_ONE};

`ifdef ROTM_SAT_EN
  localparam logic signed [WE+1:0] P_ONE = (WE+2)'(1 << WOF);
  localparam logic signed [WE+1:0] N_ONE = -P_ONE;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG_X, S_TRIG_Y, S_TRIG_Z, S_MUL1, S_MUL2, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WA-1:0]        r_ax, r_ay, r_az;
  logic signed [WE-1:0] r_sx, r_cx, r_sy, r_cy, r_sz, r_cz;
  logic signed [WE-1:0] r_sxsy, r_cxsy, r_r00, r_r10, r_r20, r_r21, r_r22;
  logic signed [WE-1:0] r_cxsz, r_sxsz, r_cxcz, r_sxcz;
  logic [9*WE-1:0]      r_m_out;

  logic [WA-1:0]        w_trig_angle;
  logic signed [WE-1:0] w_sin, w_cos;
  logic signed [WE-1:0] w_r01, w_r02, w_r11, w_r12;

  function automatic logic [WA-1:0] f_reduce(input logic [WA-1:0] a);
    logic [WA-1:0] v;
    v = (a >= TWO_PI) ? (a - TWO_PI) : a;
    return (v >= TWO_PI) ? (v - TWO_PI) : v;
  endfunction

  function automatic logic signed [WE-1:0] f_narrow(input logic signed [WE+1:0] v);
`ifdef ROTM_SAT_EN
    if (v > P_ONE) return WE'(P_ONE);
    if (v < N_ONE) return WE'(N_ONE);
`endif
    return WE'(v);
  endfunction

  // Q2.12 x Q2.12 -> Q4.24, round half up, back to Q2.12
  function automatic logic signed [WE-1:0] f_mul(input logic signed [WE-1:0] a,
                                                 input logic signed [WE-1:0] b);
    logic signed [2*WE-1:0] p;
    p = (2*WE)'(a) * (2*WE)'(b);
    return f_narrow((WE+2)'((p + (2*WE)'(1 << (WOF - 1))) >>> WOF));
  endfunction

  function automatic logic signed [WE-1:0] f_add(input logic signed [WE-1:0] a,
                                                 input logic signed [WE-1:0] b,
                                                 input logic                 sub);
    logic signed [WE:0] s;
    s = sub ? ((WE+1)'(a) - (WE+1)'(b)) : ((WE+1)'(a) + (WE+1)'(b));
    return f_narrow((WE+2)'(s));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_TRIG_X;
      S_TRIG_X: w_state_next = S_TRIG_Y;
      S_TRIG_Y: w_state_next = S_TRIG_Z;
      S_TRIG_Z: w_state_next = S_MUL1;
      S_MUL1:   w_state_next = S_MUL2;
      S_MUL2:   w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_trig_angle = '0;
    case (r_state)
      S_TRIG_X: w_trig_angle = r_ax;
      S_TRIG_Y: w_trig_angle = r_ay;
      S_TRIG_Z: w_trig_angle = r_az;
      default:  w_trig_angle = '0;
    endcase
  end

  cal_sin #(.WA(WA), .WIF(WIF), .WE(WE), .WOF(WOF)) u_sin (
    .i_angle (w_trig_angle),
    .o_sin   (w_sin)
  );

  cal_cos #(.WA(WA), .WIF(WIF), .WE(WE), .WOF(WOF)) u_cos (
    .i_angle (w_trig_angle),
    .o_cos   (w_cos)
  );

  assign w_r01 = f_add(f_mul(r_sxsy, r_cz), r_cxsz, 1'b1);
  assign w_r02 = f_add(f_mul(r_cxsy, r_cz), r_sxsz, 1'b0);
  assign w_r11 = f_add(f_mul(r_sxsy, r_sz), r_cxcz, 1'b0);
  assign w_r12 = f_add(f_mul(r_cxsy, r_sz), r_sxcz, 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax    <= '0;
      r_ay    <= '0;
      r_az    <= '0;
      r_sx    <= '0;
      r_cx    <= '0;
      r_sy    <= '0;
      r_cy    <= '0;
      r_sz    <= '0;
      r_cz    <= '0;
      r_sxsy  <= '0;
      r_cxsy  <= '0;
      r_r00   <= '0;
      r_r10   <= '0;
      r_r20   <= '0;
      r_r21   <= '0;
      r_r22   <= '0;
      r_cxsz  <= '0;
      r_sxsz  <= '0;
      r_cxcz  <= '0;
      r_sxcz  <= '0;
      r_m_out <= IDENT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ax <= f_reduce(angle_x);
            r_ay <= f_reduce(angle_y);
            r_az <= f_reduce(angle_z);
          end
        end
        S_TRIG_X: begin
          r_sx <= w_sin;
          r_cx <= w_cos;
        end
        S_TRIG_Y: begin
          r_sy <= w_sin;
          r_cy <= w_cos;
        end
        S_TRIG_Z: begin
          r_sz <= w_sin;
          r_cz <= w_cos;
        end
        S_MUL1: begin
          r_sxsy <= f_mul(r_sx, r_sy);
          r_cxsy <= f_mul(r_cx, r_sy);
          r_r00  <= f_mul(r_cy, r_cz);
          r_r10  <= f_mul(r_cy, r_sz);
          r_r21  <= f_mul(r_sx, r_cy);
          r_r22  <= f_mul(r_cx, r_cy);
          r_r20  <= -r_sy;
          r_cxsz <= f_mul(r_cx, r_sz);
          r_sxsz <= f_mul(r_sx, r_sz);
          r_cxcz <= f_mul(r_cx, r_cz);
          r_sxcz <= f_mul(r_sx, r_cz);
        end
        // the whole matrix lands at once so m_out is never seen half-updated
        S_MUL2: r_m_out <= {r_r22, r_r21, r_r20, w_r12, w_r11, r_r10, w_r02, w_r01, r_r00};
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign m_out = r_m_out;
endmodule

// File: tb/tb_rot_matrix_gen.sv
// Scoreboard bench for rot_matrix_gen: real-valued matrix reference, +-8 LSB per entry, cycle-exact handshake.
module tb_rot_matrix_gen;
  localparam logic [125:0] IDENT = {14'h1000, 14'h0, 14'h0, 14'h0, 14'h1000,
                                    14'h0, 14'h0, 14'h0, 14'h1000};
  localparam int TOL = 8;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [11:0]  angle_x = '0;
  logic [11:0]  angle_y = '0;
  logic [11:0]  angle_z = '0;
  logic         busy;
  logic         done;
  logic [125:0] m_out;

  int           total = 0;
  int           bad   = 0;
  int           runs  = 0;
  logic [125:0] exp_q[$];
  logic [125:0] got_q[$];
  logic [125:0] last_m = '0;

  rot_matrix_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .angle_x (angle_x),
    .angle_y (angle_y),
    .angle_z (angle_z),
    .busy    (busy),
    .done    (done),
    .m_out   (m_out)
  );

  always #5 clk = ~clk;

  // Angles wrap modulo 0x648; R = Rz*Ry*Rx from real sin/cos, rounded to Q2.12.
  function automatic logic [125:0] model(input int ax, input int ay, input int az);
    real x, y, z, sx, cx, sy, cy, sz, cz;
    real r[9];
    logic [125:0] res;
    int v;
    x = real'(ax % 1608) / 256.0;
    y = real'(ay % 1608) / 256.0;
    z = real'(az % 1608) / 256.0;
    sx = $sin(x); cx = $cos(x);
    sy = $sin(y); cy = $cos(y);
    sz = $sin(z); cz = $cos(z);
    r[0] = cy * cz;
    r[1] = sx * sy * cz - cx * sz;
    r[2] = cx * sy * cz + sx * sz;
    r[3] = cy * sz;
    r[4] = sx * sy * sz + cx * cz;
    r[5] = cx * sy * sz - sx * cz;
    r[6] = -sy;
    r[7] = sx * cy;
    r[8] = cx * cy;
    res = '0;
    for (int i = 0; i < 9; i++) begin
      v = $rtoi(r[i] * 4096.0 + ((r[i] >= 0.0) ? 0.5 : -0.5));
      res[14*i +: 14] = 14'(v);
    end
    return res;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic check_vec(input string nm, input logic [125:0] got, input logic [125:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic check_tol(input string nm, input logic [13:0] got, input logic [13:0] want);
    int g, w, d;
    g = int'($signed(got));
    w = int'($signed(want));
    d = (g > w) ? g - w : w - g;
    total++;
    if (d > TOL) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (+-%0d)", nm, g, w, TOL);
    end
  endtask

  // Monitor: pops one expectation per done pulse; otherwise m_out must hold.
  always @(negedge clk) begin
    logic [125:0] e;
    if (!rst_n) begin
      last_m = m_out;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1, want no pending run");
        end else begin
          e = exp_q.pop_front();
          runs++;
          $display("run %0d: m_out=%h expected=%h", runs, m_out, e);
          for (int i = 0; i < 9; i++)
            check_tol($sformatf("r%0d%0d", i / 3, i % 3), m_out[14*i +: 14], e[14*i +: 14]);
`ifdef ROTM_SAT_EN
          for (int i = 0; i < 9; i++)
            check("sat_range", int'(($signed(m_out[14*i +: 14]) > 14'sh1000) ||
                                    ($signed(m_out[14*i +: 14]) < -14'sh1000)), 0);
`endif
          got_q.push_back(m_out);
        end
      end else begin
        check_vec("m_out_hold", m_out, last_m);
      end
      last_m = m_out;
    end
  end

  // Called #1 after an edge with the DUT idle; start is sampled at the next edge k.
  task automatic run_checked(input logic [11:0] ax, input logic [11:0] ay, input logic [11:0] az);
    angle_x = ax;
    angle_y = ay;
    angle_z = az;
    start   = 1'b1;
    exp_q.push_back(model(int'(ax), int'(ay), int'(az)));
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("busy_c%0d", c), int'(busy), 1);
      check($sformatf("done_c%0d", c), int'(done), (c == 6) ? 1 : 0);
      angle_x = 12'($urandom);
      angle_y = 12'($urandom);
      angle_z = 12'($urandom);
      @(posedge clk); #1;
    end
    check("busy_after", int'(busy), 0);
    check("done_after", int'(done), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_vec("rst_m_out", m_out, IDENT);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);
    check_vec("idle_m_out", m_out, IDENT);

    run_checked(12'h000, 12'h000, 12'h000);
    run_checked(12'h000, 12'h000, 12'h192);
    run_checked(12'h000, 12'h324, 12'h000);
    run_checked(12'h000, 12'h96C, 12'h000);
    check_vec("wrap_equal", got_q[got_q.size() - 1], got_q[got_q.size() - 2]);
    run_checked(12'h647, 12'h648, 12'hC90);
    run_checked(12'hFFF, 12'h0C9, 12'h36F);
    run_checked(12'h0C9, 12'h0C9, 12'h0C9);

    // start while busy is ignored; angle change mid-run has no effect; start at k+7 accepted
    angle_x = 12'h0C9; angle_y = 12'h100; angle_z = 12'h2A0; start = 1'b1;
    exp_q.push_back(model(12'h0C9, 12'h100, 12'h2A0));
    @(posedge clk); #1 start = 1'b0;
    check("t5_busy", int'(busy), 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; angle_x = 12'h555;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("t5_done", int'(done), 1);
    angle_x = 12'h3A1; angle_y = 12'h7F0; angle_z = 12'h011; start = 1'b1;
    exp_q.push_back(model(12'h3A1, 12'h7F0, 12'h011));
    @(posedge clk); #1;
    check("t5_gap_busy", int'(busy), 0);
    @(posedge clk); #1 start = 1'b0;
    check("t5_accept_busy", int'(busy), 1);
    repeat (5) begin @(posedge clk); #1; end
    check("t5_second_done", int'(done), 1);
    @(posedge clk); #1;

    // reset during MUL1 discards the run
    angle_x = 12'h123; angle_y = 12'h456; angle_z = 12'h789; start = 1'b1;
    exp_q.push_back(model(12'h123, 12'h456, 12'h789));
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check_vec("t6_m_out", m_out, IDENT);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("t6_no_done", int'(done), 0);
    end

    // start held high: one run every 7 cycles
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      angle_x = 12'($urandom); angle_y = 12'($urandom); angle_z = 12'($urandom);
      exp_q.push_back(model(int'(angle_x), int'(angle_y), int'(angle_z)));
      @(posedge clk); #1;
      if (r == 2) start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check("cont_done", int'(done), 1);
      @(posedge clk); #1;
      check("cont_idle", int'(busy), 0);
    end

    for (int n = 0; n < 25; n++) begin
      run_checked(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending_runs", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
